add_sub_exp_align: RTL and testbench
====================================

ADD_SUB_EXP_ALIGN -- requirements
Module: add_sub_exp_align

Interface
REQ-001 SHALL have parameter SIZE_EXP, default 8, exponent width.
REQ-002 SHALL have parameter SIZE_MAN, default 24, mantissa width including hidden bit, supplied by caller.
REQ-003 SHALL have parameter SHIFT_STEP, default 8, maximum right-shift bits per cycle.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  clock; all state updates on rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  operand pair valid.
REQ-008 o_ready  output  1  block can accept operands.
REQ-009 i_exp_a, i_exp_b  input  SIZE_EXP  biased exponents.
REQ-010 i_man_a, i_man_b  input  SIZE_MAN  mantissas.
REQ-011 o_valid  output  1  aligned result valid.
REQ-012 i_ready  input  1  downstream accepts result.
REQ-013 o_exp_max  output  SIZE_EXP  larger exponent, the pre-normalisation exponent.
REQ-014 o_man_large  output  SIZE_MAN  mantissa of larger operand, unshifted.
REQ-015 o_man_small  output  SIZE_MAN+3  smaller mantissa, aligned, with guard/round/sticky as bits [2:0].
REQ-016 o_swap  output  1  1 when operand B is the larger operand.
REQ-017 o_shift_amt  output  SIZE_EXP  unclamped exponent difference.

Function
REQ-018 FSM states: IDLE, COMPARE, SHIFT, DONE; o_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on i_valid&o_ready, SHALL register all operands and go to COMPARE; otherwise stay.
REQ-020 COMPARE: swap=1 if exp_b>exp_a, or exps equal and man_b>man_a; else 0. Ties (equal exps and mantissas) SHALL give swap=0.
REQ-021 COMPARE: SHALL set diff=|exp_a-exp_b| with no wrap; remaining=min(diff, SIZE_MAN+2); ext={man_small,3'b000}.
REQ-022 COMPARE: SHALL go to DONE if remaining=0; otherwise go to SHIFT.
REQ-023 SHIFT: each cycle, with k=min(remaining, SHIFT_STEP): ext <= ext>>k; new ext[0] |= OR of old ext[k-1:0] (sticky); remaining -= k.
REQ-024 SHIFT: SHALL go to DONE when remaining reaches 0; shift cycles = ceil(remaining/SHIFT_STEP).
REQ-025 Latency: accept at cycle T; o_valid SHALL assert at T+2+shift cycles (max T+6 with defaults).
REQ-026 DONE: o_valid=1; all outputs SHALL be held stable until i_ready=1, then go to IDLE (o_ready=1 the next cycle).
REQ-027 The block SHALL NOT accept a new pair in the cycle o_valid&i_ready completes.
REQ-028 All outputs SHALL be registered; no combinational path from i_ready to o_valid.
REQ-029 Exponent 0 and mantissa 0 SHALL get no special handling; a zero small mantissa SHALL give o_man_small=0 with sticky 0.

Reset
REQ-030 On i_rst=1, SHALL go to IDLE next edge from any state, dropping any in-flight operation.
REQ-031 Reset values: o_valid=0, o_ready=1 (IDLE), o_exp_max=0, o_man_large=0, o_man_small=0, o_swap=0, o_shift_amt=0.
REQ-032 i_rst SHALL override i_valid in the same cycle; no operand is captured.

Verification
REQ-033 exp_a=0x80, man_a=0x800000, exp_b=0x80, man_b=0xC00000 -> swap=1, exp_max=0x80, man_large=0xC00000, man_small=0x4000000, shift_amt=0, o_valid at T+2.
REQ-034 exp_a=0x83, man_a=0x800000, exp_b=0x80, man_b=0xFFFFFF -> swap=0, exp_max=0x83, man_small=0x0FFFFFF, shift_amt=3, o_valid at T+3.
REQ-035 exp_a=0x8A, exp_b=0x80, man_b=0x800001 -> man_small=0x0010001 (sticky set), shift_amt=10, two shift cycles, o_valid at T+4.
REQ-036 exp_a=0x90, exp_b=0x68, man_b=0x800000 -> shift_amt=0x28, clamp to 26, man_small=0x0000001, o_valid at T+6; repeat with man_b=0 -> man_small=0.
REQ-037 Hold i_ready=0 for 5 cycles in DONE -> o_valid and all outputs stable, o_ready=0; i_ready=1 -> IDLE, o_ready=1 next cycle.
REQ-038 Pulse i_rst during SHIFT of the REQ-036 case -> o_valid never asserts, all outputs at reset values, o_ready=1 next cycle; a new pair then completes normally.

Source files
------------

// File: rtl/add_sub_exp_align.sv
// Floating-point add/sub front end: picks the larger operand, then right-aligns
// the smaller mantissa by the exponent difference, a few bits per cycle, while
// folding every bit shifted out into a sticky bit (guard/round/sticky in [2:0]).
module add_sub_exp_align #(
  parameter int SIZE_EXP   = 8,
  parameter int SIZE_MAN   = 24,
  parameter int SHIFT_STEP = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZE_EXP-1:0] i_exp_a,
  input  logic [SIZE_EXP-1:0] i_exp_b,
  input  logic [SIZE_MAN-1:0] i_man_a,
  input  logic [SIZE_MAN-1:0] i_man_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_EXP-1:0] o_exp_max,
  output logic [SIZE_MAN-1:0] o_man_large,
  output logic [SIZE_MAN+2:0] o_man_small,
  output logic                o_swap,
  output logic [SIZE_EXP-1:0] o_shift_amt
);

  // Shifting further than the extended width only moves bits into sticky.
  localparam int EXT_W     = SIZE_MAN + 3;
  localparam int MAX_SHIFT = SIZE_MAN + 2;
  localparam int REM_W     = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SIZE_EXP-1:0] exp_a_q, exp_b_q;
  logic [SIZE_MAN-1:0] man_a_q, man_b_q;
  logic [REM_W-1:0]    remaining_q;

  // Operand comparison, evaluated on the captured operands during COMPARE.
  logic                swap_c;
  logic [SIZE_EXP-1:0] diff_c;
  logic [REM_W-1:0]    remaining_c;

  // One alignment step on the extended mantissa (o_man_small is the shifter).
  logic [REM_W-1:0]    k_c;
  logic [EXT_W-1:0]    lost_mask_c;
  logic                sticky_c;
  logic [EXT_W-1:0]    ext_shifted_c;
  logic [REM_W-1:0]    remaining_next_c;

  // Compare operands and compute the clamped shift distance.
  always_comb begin
    swap_c = (exp_b_q > exp_a_q) || ((exp_b_q == exp_a_q) && (man_b_q > man_a_q));
    diff_c = (exp_a_q >= exp_b_q) ? (exp_a_q - exp_b_q) : (exp_b_q - exp_a_q);
    if (int'(diff_c) > MAX_SHIFT)
      remaining_c = REM_W'(MAX_SHIFT);
    else
      remaining_c = REM_W'(diff_c);
  end

  // Shift by at most SHIFT_STEP, OR-ing the discarded bits into bit 0.
  always_comb begin
    if (int'(remaining_q) > SHIFT_STEP)
      k_c = REM_W'(SHIFT_STEP);
    else
      k_c = remaining_q;
    lost_mask_c      = ~({EXT_W{1'b1}} << k_c);
    sticky_c         = |(o_man_small & lost_mask_c);
    ext_shifted_c    = (o_man_small >> k_c) | {{(EXT_W-1){1'b0}}, sticky_c};
    remaining_next_c = remaining_q - k_c;
  end

  // Next-state logic.
  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = COMPARE;
      COMPARE: state_d = (remaining_c == '0) ? DONE : SHIFT;
      SHIFT:   if (remaining_next_c == '0) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation.
  // NOTE: sequential blocks use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and registered handshake outputs (o_valid/o_ready follow the next state,
  // so i_ready only reaches them through a flop).
  // NOTE: the operand registers are plain flops, so they are reset together with the outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      man_a_q     <= '0;
      man_b_q     <= '0;
      remaining_q <= '0;
      o_valid     <= 1'b0;
      o_ready     <= 1'b1;
      o_exp_max   <= '0;
      o_man_large <= '0;
      o_man_small <= '0;
      o_swap      <= 1'b0;
      o_shift_amt <= '0;
    end else begin
      o_valid <= (state_d == DONE);
      o_ready <= (state_d == IDLE);
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            exp_a_q <= i_exp_a;
            exp_b_q <= i_exp_b;
            man_a_q <= i_man_a;
            man_b_q <= i_man_b;
          end
        end
        COMPARE: begin
          o_swap      <= swap_c;
          o_exp_max   <= swap_c ? exp_b_q : exp_a_q;
          o_man_large <= swap_c ? man_b_q : man_a_q;
          o_shift_amt <= diff_c;
          remaining_q <= remaining_c;
          o_man_small <= {(swap_c ? man_a_q : man_b_q), 3'b000};
        end
        SHIFT: begin
          o_man_small <= ext_shifted_c;
          remaining_q <= remaining_next_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_exp_align.sv
// Self-checking bench for add_sub_exp_align (default parameters).
module tb_add_sub_exp_align;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_exp_a, i_exp_b;
  logic [23:0] i_man_a, i_man_b;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exp_max;
  logic [23:0] o_man_large;
  logic [26:0] o_man_small;
  logic        o_swap;
  logic [7:0]  o_shift_amt;

  int checks   = 0;
  int failures = 0;

  add_sub_exp_align dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_exp_a(i_exp_a), .i_exp_b(i_exp_b), .i_man_a(i_man_a), .i_man_b(i_man_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_exp_max(o_exp_max),
    .o_man_large(o_man_large), .o_man_small(o_man_small), .o_swap(o_swap),
    .o_shift_amt(o_shift_amt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        swap;
    logic [7:0]  exp_max;
    logic [23:0] man_large;
    logic [26:0] man_small;
    logic [7:0]  shift_amt;
    int          lat;
  } model_t;

  model_t cur;
  bit     pending = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Whole-operation model: one big shift with all discarded bits as sticky.
  function automatic model_t model(input logic [7:0] ea, input logic [23:0] ma,
                                   input logic [7:0] eb, input logic [23:0] mb);
    model_t m;
    longint unsigned ext, lost;
    int diff, amt;
    m.swap      = (eb > ea) || ((eb == ea) && (mb > ma));
    m.exp_max   = m.swap ? eb : ea;
    m.man_large = m.swap ? mb : ma;
    diff        = (ea > eb) ? (int'(ea) - int'(eb)) : (int'(eb) - int'(ea));
    m.shift_amt = diff[7:0];
    amt         = (diff > 26) ? 26 : diff;
    ext         = 64'(m.swap ? ma : mb) << 3;
    lost        = ext & ((64'd1 << amt) - 64'd1);
    m.man_small = 27'((ext >> amt) | ((lost != 0) ? 64'd1 : 64'd0));
    m.lat       = 2 + (amt + 7) / 8;
    return m;
  endfunction

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (!pending) begin
        check("unexpected_valid", o_valid, 1'b0);
      end else begin
        check("cmp_swap",      o_swap,      cur.swap);
        check("cmp_exp_max",   o_exp_max,   cur.exp_max);
        check("cmp_man_large", o_man_large, cur.man_large);
        check("cmp_man_small", o_man_small, cur.man_small);
        check("cmp_shift_amt", o_shift_amt, cur.shift_amt);
        check("cmp_ready_low", o_ready,     1'b0);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},     o_valid,     1'b0);
    check({tag, "_ready"},     o_ready,     1'b1);
    check({tag, "_exp_max"},   o_exp_max,   '0);
    check({tag, "_man_large"}, o_man_large, '0);
    check({tag, "_man_small"}, o_man_small, '0);
    check({tag, "_swap"},      o_swap,      1'b0);
    check({tag, "_shift_amt"}, o_shift_amt, '0);
  endtask

  // Present one operand pair at a negedge; returns with the DUT accepted.
  task automatic offer(input logic [7:0] ea, input logic [23:0] ma,
                       input logic [7:0] eb, input logic [23:0] mb);
    check("ready_before_offer", o_ready, 1'b1);
    i_exp_a = ea; i_man_a = ma; i_exp_b = eb; i_man_b = mb;
    i_valid = 1'b1;
    cur     = model(ea, ma, eb, mb);
    pending = 1'b1;
    @(posedge i_clk);
  endtask

  // Full transaction with hand-computed literal expectations.
  task automatic run_op(input string tag,
                        input logic [7:0] ea, input logic [23:0] ma,
                        input logic [7:0] eb, input logic [23:0] mb,
                        input logic [26:0] lit_small, input logic lit_swap,
                        input logic [7:0] lit_amt, input int lit_lat, input int hold);
    int n;
    bit got;
    offer(ea, ma, eb, mb);
    @(negedge i_clk);
    i_valid = 1'b0;
    n   = 1;
    got = o_valid;
    while (!got && n < 20) begin
      @(posedge i_clk);
      n++;
      @(negedge i_clk);
      got = o_valid;
    end
    check({tag, "_valid_seen"}, got, 1'b1);
    check({tag, "_latency"}, n, lit_lat);
    check({tag, "_latency_model"}, n, cur.lat);
    check({tag, "_man_small"}, o_man_small, lit_small);
    check({tag, "_swap"}, o_swap, lit_swap);
    check({tag, "_shift_amt"}, o_shift_amt, lit_amt);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      check({tag, "_hold_valid"}, o_valid, 1'b1);
      check({tag, "_hold_ready"}, o_ready, 1'b0);
    end
    // Complete the handshake while offering another pair; it must be refused.
    i_ready = 1'b1;
    i_valid = 1'b1;
    @(posedge i_clk);
    pending = 1'b0;
    @(negedge i_clk);
    i_ready = 1'b0;
    i_valid = 1'b0;
    check({tag, "_after_valid"}, o_valid, 1'b0);
    check({tag, "_after_ready"}, o_ready, 1'b1);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    i_exp_a = 8'h90; i_man_a = 24'h800000; i_exp_b = 8'h68; i_man_b = 24'h800000;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_values("reset");
    i_rst = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("post_reset_ready", o_ready, 1'b1);

    run_op("eq_exp_swap", 8'h80, 24'h800000, 8'h80, 24'hC00000, 27'h4000000, 1'b1, 8'h00, 2, 0);
    check("eq_exp_swap_exp_max",   o_exp_max,   8'h80);
    check("eq_exp_swap_man_large", o_man_large, 24'hC00000);
    run_op("shift3", 8'h83, 24'h800000, 8'h80, 24'hFFFFFF, 27'h0FFFFFF, 1'b0, 8'h03, 3, 0);
    check("shift3_exp_max", o_exp_max, 8'h83);
    run_op("shift10", 8'h8A, 24'h800000, 8'h80, 24'h800001, 27'h0010001, 1'b0, 8'h0A, 4, 0);
    run_op("clamp", 8'h90, 24'h800000, 8'h68, 24'h800000, 27'h0000001, 1'b0, 8'h28, 6, 0);
    run_op("clamp_zero", 8'h90, 24'h800000, 8'h68, 24'h000000, 27'h0000000, 1'b0, 8'h28, 6, 0);
    run_op("tie", 8'h7F, 24'hA00000, 8'h7F, 24'hA00000, 27'h5000000, 1'b0, 8'h00, 2, 0);
    run_op("b_larger", 8'h10, 24'hFFFFFF, 8'h11, 24'h800000, 27'h3FFFFFC, 1'b1, 8'h01, 3, 0);
    run_op("exp_zero", 8'h00, 24'h800000, 8'hFF, 24'h800000, 27'h0000001, 1'b1, 8'hFF, 6, 0);
    run_op("sticky_only", 8'h20, 24'h000001, 8'h3A, 24'h800000, 27'h0000001, 1'b1, 8'h1A, 6, 0);
    run_op("hold5", 8'h83, 24'h800000, 8'h80, 24'hFFFFFF, 27'h0FFFFFF, 1'b0, 8'h03, 3, 5);

    // Reset in the middle of the shift phase.
    offer(8'h90, 24'h800000, 8'h68, 24'h800000);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_valid = 1'b1;
    pending = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check_reset_values("mid_shift_reset");
    i_rst   = 1'b0;
    i_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      check("aborted_no_valid", o_valid, 1'b0);
    end
    run_op("after_abort", 8'h8A, 24'h800000, 8'h80, 24'h800001, 27'h0010001, 1'b0, 8'h0A, 4, 2);

    repeat (2) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
